// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with an internal 16x oversample prescaler and 2-of-3 mid-bit voting.
// It rejects false starts, flags bad stop bits, and holds one byte with an overrun flag.
module uart_rx_os16 #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  // state      | meaning
  // ST_IDLE    | line idle, waiting for a low rx_s on an os_tick
  // ST_START   | verifying the start bit at mid-bit
  // ST_DATA    | shifting in 8 data bits, LSB first
  // ST_STOP    | checking the stop bit, then commit or frame error
  // ST_WAIT    | after a frame error, waiting for the line to return high
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    s_q, s_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    smp_q, smp_d;
  logic [7:0]    data_q, data_d;
  logic          data_ready_q, data_ready_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic rx_s;
  logic os_tick;
  logic bit_dec;
  logic commit;
  logic ferr;

  assign rx_s    = sync_q[1];
  assign os_tick = (presc_q == DIV_LAST);
  // The third vote is the live sample taken on the s=9 tick itself.
  assign bit_dec = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  always_comb begin
    sync_d  = {sync_q[0], rxd};
    presc_d = os_tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    commit  = 1'b0;
    ferr    = 1'b0;
    if (os_tick) begin
      if (s_q == 4'd7) smp_d[0] = rx_s;
      if (s_q == 4'd8) smp_d[1] = rx_s;
      case (state_q)
        ST_IDLE: begin
          s_d = 4'd0;
          if (!rx_s) state_d = ST_START;
        end
        ST_START: begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd9 && bit_dec) begin
            state_d = ST_IDLE;
          end else if (s_q == 4'd15) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end
        ST_DATA: begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd9) shift_d = {bit_dec, shift_q[7:1]};
          if (s_q == 4'd15) begin
            if (idx_q == 3'd7) state_d = ST_STOP;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        ST_STOP: begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd9) begin
            if (bit_dec) begin
              commit  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr    = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A commit coinciding with rd_ack keeps the new byte pending but leaves overrun clear.
  always_comb begin
    valid_d      = commit;
    frame_err_d  = ferr;
    data_d       = commit ? shift_q : data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    if (commit) begin
      data_ready_d = 1'b1;
      overrun_d    = rd_ack ? 1'b0 : (overrun_q | data_ready_q);
    end else if (rd_ack) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sync_q       <= 2'b11;
      presc_q      <= '0;
      s_q          <= 4'd0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      smp_q        <= 2'b11;
      data_q       <= 8'd0;
      data_ready_q <= 1'b0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      presc_q      <= presc_d;
      s_q          <= s_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      smp_q        <= smp_d;
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign data_ready = data_ready_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed scenarios plus random frames,
// compared against a byte-level model of the holding register and pulse counts.
module tb_uart_rx_os16;

  localparam int BIT_CLK  = 434;
  localparam int DIV      = 27;
  localparam int NO_SPIKE = -1000000;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] data;
  logic       data_ready;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_os16 dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rd_ack     (rd_ack),
    .data       (data),
    .data_ready (data_ready),
    .valid      (valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; the DUT prescaler is at cyc % DIV.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int   n_valid, valid_hi, last_valid_cyc, n_ferr, ferr_hi, busy_cycles;
  logic valid_prev, ferr_prev;
  initial begin
    n_valid = 0; valid_hi = 0; last_valid_cyc = -1;
    n_ferr = 0; ferr_hi = 0; busy_cycles = 0;
    valid_prev = 1'b0; ferr_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (valid) valid_hi <= valid_hi + 1;
    if (valid && !valid_prev) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err) ferr_hi <= ferr_hi + 1;
    if (frame_err && !ferr_prev) n_ferr <= n_ferr + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    valid_prev <= valid;
    ferr_prev  <= frame_err;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_data;
  logic       exp_ready;
  logic       exp_ovr;
  int         exp_nvalid;
  int         exp_nferr;

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack);
    if (stop_ok) begin
      exp_nvalid++;
      if (ack)            exp_ovr = 1'b0;
      else if (exp_ready) exp_ovr = 1'b1;
      exp_data  = b;
      exp_ready = 1'b1;
    end else begin
      exp_nferr++;
    end
  endtask

  task automatic model_ack();
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".data"},       data,       exp_data);
    check_eq({tag, ".data_ready"}, data_ready, exp_ready);
    check_eq({tag, ".overrun"},    overrun,    exp_ovr);
    check_eq({tag, ".n_valid"},    n_valid,    exp_nvalid);
    check_eq({tag, ".n_ferr"},     n_ferr,     exp_nferr);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    model_ack();
  endtask

  // Drives nbits bit slots of an 8N1 frame. The start edge reaches rx_s two clocks after it is
  // driven and is seen on the next prescaler tick t0; the stop-bit vote lands 154 ticks later.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int nbits,
                            input int spike_rel, input bit ack_commit, output int t_commit);
    logic [9:0] fr;
    int j0;
    int t0;
    fr = {stop_ok, b, 1'b0};
    @(negedge clk);
    j0       = cyc;
    t0       = j0 + 2 + (DIV - 1 - ((j0 + 2) % DIV));
    t_commit = t0 + DIV * 154;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        rxd    = (cyc == t0 + spike_rel) ? ~fr[k] : fr[k];
        rd_ack = ack_commit && (cyc == t_commit);
        @(negedge clk);
      end
    end
    rd_ack = 1'b0;
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  int         tc;
  int         snap_valid, snap_ferr, snap_busy;
  logic [7:0] rb;
  bit         rok, rak;

  initial begin
    rst = 1'b1; rxd = 1'b1; rd_ack = 1'b0;
    exp_nvalid = 0; exp_nferr = 0;
    model_reset();
    wait_clks(4);
    check_eq("rst.data",       data,       8'h00);
    check_eq("rst.data_ready", data_ready, 1'b0);
    check_eq("rst.valid",      valid,      1'b0);
    check_eq("rst.frame_err",  frame_err,  1'b0);
    check_eq("rst.overrun",    overrun,    1'b0);
    check_eq("rst.busy",       busy,       1'b0);
    rst = 1'b0;
    wait_clks(2 * BIT_CLK);

    // 1: single good frame, also checks commit timing
    send_frame(8'hB3, 1'b1, 10, NO_SPIKE, 1'b0, tc);
    model_frame(8'hB3, 1'b1, 1'b0);
    wait_clks(BIT_CLK);
    check_state("t1");
    check_eq("t1.valid_cycle", last_valid_cyc, tc + 1);
    check_eq("t1.busy", busy, 1'b0);

    // 2: short glitch on idle line is a false start
    snap_valid = n_valid; snap_ferr = n_ferr; snap_busy = busy_cycles;
    @(negedge clk);
    rxd = 1'b0;
    wait_clks(100);
    rxd = 1'b1;
    wait_clks(10 * 16 * DIV - 100);
    check_eq("t2.busy_seen", busy_cycles > snap_busy, 1'b1);
    check_eq("t2.busy_end",  busy,     1'b0);
    check_eq("t2.no_valid",  n_valid,  snap_valid);
    check_eq("t2.no_ferr",   n_ferr,   snap_ferr);
    check_state("t2");

    // 3: bad stop bit, line stays low, then recovers
    send_frame(8'h55, 1'b0, 10, NO_SPIKE, 1'b0, tc);
    model_frame(8'h55, 1'b0, 1'b0);
    check_eq("t3.busy_low_line", busy, 1'b1);
    wait_clks(300);
    check_eq("t3.busy_held", busy, 1'b1);
    check_state("t3");
    rxd = 1'b1;
    wait_clks(200);
    check_eq("t3.busy_released", busy, 1'b0);

    // 4: two frames back-to-back without a read produce overrun
    pulse_ack();
    check_eq("t4.ack_clears", data_ready, 1'b0);
    send_frame(8'h12, 1'b1, 10, NO_SPIKE, 1'b0, tc);
    model_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 10, NO_SPIKE, 1'b0, tc);
    model_frame(8'h34, 1'b1, 1'b0);
    wait_clks(BIT_CLK);
    check_state("t4");
    pulse_ack();
    wait_clks(2);
    check_state("t4.ack");

    // 5: reset in the middle of a frame, then a clean frame
    send_frame(8'h5A, 1'b1, 5, NO_SPIKE, 1'b0, tc);
    rst = 1'b1;
    #1;
    check_eq("t5.data",       data,       8'h00);
    check_eq("t5.data_ready", data_ready, 1'b0);
    check_eq("t5.valid",      valid,      1'b0);
    check_eq("t5.frame_err",  frame_err,  1'b0);
    check_eq("t5.overrun",    overrun,    1'b0);
    check_eq("t5.busy",       busy,       1'b0);
    rxd = 1'b1;
    model_reset();
    wait_clks(3);
    rst = 1'b0;
    wait_clks(BIT_CLK);
    send_frame(8'hA5, 1'b1, 10, NO_SPIKE, 1'b0, tc);
    model_frame(8'hA5, 1'b1, 1'b0);
    wait_clks(BIT_CLK);
    check_state("t5.after");

    // 6: one-clock spike on the middle vote of data bit 2, rd_ack on the commit clock
    send_frame(8'h0F, 1'b1, 10, DIV * 57 - 2, 1'b1, tc);
    model_frame(8'h0F, 1'b1, 1'b1);
    wait_clks(BIT_CLK / 2);
    check_state("t6");
    check_eq("t6.valid_cycle", last_valid_cyc, tc + 1);

    // random frames, stop bits, commit-aligned and idle acks
    for (int i = 0; i < 6; i++) begin
      rb  = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 3) != 0);
      rak = rok && ($urandom_range(0, 2) == 0);
      send_frame(rb, rok, 10, NO_SPIKE, rak, tc);
      model_frame(rb, rok, rak);
      if (!rok) begin
        wait_clks(int'($urandom_range(0, 200)));
        rxd = 1'b1;
        wait_clks(500);
      end else if ($urandom_range(0, 1) == 1) begin
        wait_clks(100);
      end
      check_state($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack();
        wait_clks(2);
        check_state($sformatf("rnd%0d.ack", i));
      end
    end

    wait_clks(BIT_CLK);
    check_eq("end.valid_width", valid_hi, exp_nvalid);
    check_eq("end.ferr_width",  ferr_hi,  exp_nferr);
    check_eq("end.busy",        busy,     1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
